// File: rtl/itcm_pkg.sv
// itcm_pkg
//   Shared definitions for the instruction-side memory responder:
//   index-width helper, latency bound and elaboration-time legality checks.
package itcm_pkg;

    // Deepest response pipeline the responder supports.
    localparam int unsigned ITCM_LAT_MAX = 4;

    // Word-index width for an array of 'depth' words.
    function automatic int unsigned itcm_idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // LATENCY must lie in 1..ITCM_LAT_MAX.
    function automatic bit itcm_lat_ok(input int unsigned lat);
        return (lat >= 1) && (lat <= ITCM_LAT_MAX);
    endfunction

    // DEPTH must be a non-zero power of two.
    function automatic bit itcm_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage : itcm_pkg

// File: rtl/itcm_responder_sram.sv
// itcm_sram
//   Single-port instruction array: one write port, one synchronous read
//   port with read-enable. A write in the same cycle as a read wins and
//   the read is dropped (the responder never issues both together).
// Ports:
//   clk    - clock
//   we     - write strobe
//   waddr  - write word index
//   wdata  - write data
//   re     - read enable
//   raddr  - read word index
//   rdata  - read data, valid the cycle after re (holds otherwise)
module itcm_sram #(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : itcm_sram

// File: rtl/itcm_responder.sv
// itcm_responder
//   Slave end of the instruction fetch bus. Accepts one fetch per cycle,
//   reads a DW-bit word from the local array and returns it LATENCY
//   cycles later. Kill drops all in-flight responses. A side-band load
//   port fills the array and has priority over fetches.
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   ifu_req_kill        - flush in-flight responses
//   ifu_mstReq_valid    - fetch request valid
//   ifu_mstReq_ready    - fetch can be accepted this cycle (combinational)
//   ifu_addr            - fetch byte address, bits [2:0] ignored
//   ifu_data_r          - response data (0 on error / when idle)
//   ifu_slvRsp_valid    - response valid, one pulse per accepted fetch
//   ifu_slvRsp_err      - response address was outside the array window
//   ld_en/ld_idx/ld_data - load-port write into the array
module itcm_responder
    import itcm_pkg::*;
#(
    parameter int unsigned DW      = 64,
    parameter int unsigned DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         ifu_req_kill,
    input  logic                         ifu_mstReq_valid,
    output logic                         ifu_mstReq_ready,
    input  logic [63:0]                  ifu_addr,
    output logic [DW-1:0]                ifu_data_r,
    output logic                         ifu_slvRsp_valid,
    output logic                         ifu_slvRsp_err,
    input  logic                         ld_en,
    input  logic [itcm_idx_w(DEPTH)-1:0] ld_idx,
    input  logic [DW-1:0]                ld_data
);

    localparam int unsigned IW = itcm_idx_w(DEPTH);

    if (!itcm_lat_ok(LATENCY)) begin : g_bad_latency
        $error("itcm_responder: LATENCY %0d outside 1..%0d", LATENCY, ITCM_LAT_MAX);
    end
    if (!itcm_pow2(DEPTH)) begin : g_bad_depth
        $error("itcm_responder: DEPTH %0d is not a power of two", DEPTH);
    end
    if ((BASE % (64'(DEPTH) * 64'd8)) != 64'd0) begin : g_bad_base
        $error("itcm_responder: BASE not aligned to DEPTH*8");
    end

    // ------------------------------------------------------------------
    // Acceptance and address decode
    // ------------------------------------------------------------------
    logic          acc;
    logic          in_range;
    logic [60:0]   word_off;
    logic [IW-1:0] idx;
    logic          unused_addr_lsb;

    assign ifu_mstReq_ready = ~RST & ~ifu_req_kill & ~ld_en;
    assign acc              = ifu_mstReq_valid & ifu_mstReq_ready;

    // Subtraction in 61 bits: addresses below BASE wrap to a huge offset
    // and therefore fail the range compare.
    assign word_off        = ifu_addr[63:3] - BASE[63:3];
    assign in_range        = word_off < 61'(DEPTH);
    assign idx             = ifu_addr[IW+2:3];
    assign unused_addr_lsb = ^ifu_addr[2:0];

    // ------------------------------------------------------------------
    // Array
    // ------------------------------------------------------------------
    logic [DW-1:0] rdata;

    itcm_sram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_sram (
        .clk   (CLK),
        .we    (ld_en),
        .waddr (ld_idx),
        .wdata (ld_data),
        .re    (acc & in_range),
        .raddr (idx),
        .rdata (rdata)
    );

    // ------------------------------------------------------------------
    // Valid / error pipeline
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] err_q;

    always_ff @(posedge CLK) begin
        if (RST || ifu_req_kill) begin
            vld <= '0;
        end else begin
            vld[0] <= acc;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // err travels with its valid bit; a killed entry's err is never seen
    // because the output is qualified by vld.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= '0;
        end else begin
            if (acc) begin
                err_q[0] <= ~in_range;
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                if (vld[i-1]) begin
                    err_q[i] <= err_q[i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Data pipeline: stage 0 is the array read register itself, forced to
    // zero for out-of-range fetches since the read was suppressed.
    // ------------------------------------------------------------------
    logic [DW-1:0] data0;
    logic [DW-1:0] data_last;

    assign data0 = err_q[0] ? '0 : rdata;

    if (LATENCY == 1) begin : g_lat1
        assign data_last = data0;
    end else begin : g_latn
        // data_q[j] holds pipeline stage j+1
        logic [DW-1:0] data_q [LATENCY-1];

        always_ff @(posedge CLK) begin
            if (RST) begin
                for (int unsigned j = 0; j < LATENCY - 1; j++) begin
                    data_q[j] <= '0;
                end
            end else begin
                if (vld[0]) begin
                    data_q[0] <= data0;
                end
                for (int unsigned j = 1; j < LATENCY - 1; j++) begin
                    if (vld[j]) begin
                        data_q[j] <= data_q[j-1];
                    end
                end
            end
        end

        assign data_last = data_q[LATENCY-2];
    end

    // ------------------------------------------------------------------
    // Outputs: qualified by the last valid bit so idle/reset reads as zero
    // ------------------------------------------------------------------
    assign ifu_slvRsp_valid = vld[LATENCY-1];
    assign ifu_slvRsp_err   = vld[LATENCY-1] & err_q[LATENCY-1];
    assign ifu_data_r       = vld[LATENCY-1] ? data_last : '0;

endmodule : itcm_responder

// File: tb/tb_itcm_responder.sv
// tb_itcm_responder
//   Directed-vector bench for itcm_responder at LATENCY = 2, DEPTH = 1024,
//   BASE = 0x8000_0000. Expected values are hand-computed constants.
module tb_itcm_responder;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned IW    = 10;

    localparam logic [63:0] A00 = 64'h8000_0000;
    localparam logic [63:0] A08 = 64'h8000_0008;
    localparam logic [63:0] A10 = 64'h8000_0010;
    localparam logic [63:0] A18 = 64'h8000_0018;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ifu_req_kill;
    logic          ifu_mstReq_valid;
    logic          ifu_mstReq_ready;
    logic [63:0]   ifu_addr;
    logic [DW-1:0] ifu_data_r;
    logic          ifu_slvRsp_valid;
    logic          ifu_slvRsp_err;
    logic          ld_en;
    logic [IW-1:0] ld_idx;
    logic [DW-1:0] ld_data;

    int nvec = 0;
    int nmis = 0;

    itcm_responder #(
        .DW      (DW),
        .DEPTH   (DEPTH),
        .BASE    (64'h8000_0000),
        .LATENCY (2)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .ifu_req_kill     (ifu_req_kill),
        .ifu_mstReq_valid (ifu_mstReq_valid),
        .ifu_mstReq_ready (ifu_mstReq_ready),
        .ifu_addr         (ifu_addr),
        .ifu_data_r       (ifu_data_r),
        .ifu_slvRsp_valid (ifu_slvRsp_valid),
        .ifu_slvRsp_err   (ifu_slvRsp_err),
        .ld_en            (ld_en),
        .ld_idx           (ld_idx),
        .ld_data          (ld_data)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one fetch cycle, advance an edge, then check the response.
    task automatic cyc(input logic v, input logic [63:0] a, input logic ev,
                       input logic [63:0] ed, input logic ee, input string tag);
        ifu_mstReq_valid = v;
        ifu_addr         = a;
        tick();
        check_vec({tag, "/valid"}, 64'(ifu_slvRsp_valid), 64'(ev));
        if (ev) begin
            check_vec({tag, "/data"}, ifu_data_r, ed);
            check_vec({tag, "/err"}, 64'(ifu_slvRsp_err), 64'(ee));
        end
    endtask

    task automatic load(input logic [IW-1:0] i, input logic [63:0] d);
        ld_en   = 1'b1;
        ld_idx  = i;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    initial begin
        RST              = 1'b1;
        ifu_req_kill     = 1'b0;
        ifu_mstReq_valid = 1'b0;
        ifu_addr         = '0;
        ld_en            = 1'b0;
        ld_idx           = '0;
        ld_data          = '0;

        // Reset state
        tick();
        tick();
        check_vec("rst/ready", 64'(ifu_mstReq_ready), 64'd0);
        check_vec("rst/valid", 64'(ifu_slvRsp_valid), 64'd0);
        check_vec("rst/err", 64'(ifu_slvRsp_err), 64'd0);
        check_vec("rst/data", ifu_data_r, 64'd0);
        RST = 1'b0;
        #1;
        check_vec("idle/ready", 64'(ifu_mstReq_ready), 64'd1);

        // Preload; ready must drop while the load strobe is up
        ld_en = 1'b1;
        #1;
        check_vec("load/ready", 64'(ifu_mstReq_ready), 64'd0);
        load(10'd0, 64'h11);
        load(10'd1, 64'h22);
        load(10'd2, 64'h33);
        load(10'd3, 64'h44);
        load(10'd1023, 64'h5A5A);

        // Back-to-back fetches: three consecutive responses
        cyc(1'b1, A00, 1'b0, 64'h0,  1'b0, "b2b0");
        cyc(1'b1, A08, 1'b1, 64'h11, 1'b0, "b2b1");
        cyc(1'b1, A10, 1'b1, 64'h22, 1'b0, "b2b2");
        cyc(1'b0, A00, 1'b1, 64'h33, 1'b0, "b2b3");
        cyc(1'b0, A00, 1'b0, 64'h0,  1'b0, "b2b4");

        // Low address bits ignored
        cyc(1'b1, 64'h8000_0005, 1'b0, 64'h0,  1'b0, "lsb0");
        cyc(1'b0, A00,           1'b1, 64'h11, 1'b0, "lsb1");

        // Out of range below and above the window, and the last in-range word
        cyc(1'b1, 64'h7FFF_FFF8, 1'b0, 64'h0,    1'b0, "oor0");
        cyc(1'b1, 64'h8000_2000, 1'b1, 64'h0,    1'b1, "oor1");
        cyc(1'b1, 64'h8000_1FF8, 1'b1, 64'h0,    1'b1, "oor2");
        cyc(1'b0, A00,           1'b1, 64'h5A5A, 1'b0, "edge");
        cyc(1'b0, A00,           1'b0, 64'h0,    1'b0, "oor_idle");

        // Kill with two accepted requests
        cyc(1'b1, A00, 1'b0, 64'h0,  1'b0, "kill_a0");
        cyc(1'b1, A08, 1'b1, 64'h11, 1'b0, "kill_a1");
        ifu_mstReq_valid = 1'b1;
        ifu_addr         = A10;
        ifu_req_kill     = 1'b1;
        #1;
        check_vec("kill/ready", 64'(ifu_mstReq_ready), 64'd0);
        tick();
        ifu_req_kill = 1'b0;
        check_vec("kill/drop", 64'(ifu_slvRsp_valid), 64'd0);
        cyc(1'b0, A00, 1'b0, 64'h0,  1'b0, "kill_quiet");
        cyc(1'b1, A10, 1'b0, 64'h0,  1'b0, "kill_new0");
        cyc(1'b0, A00, 1'b1, 64'h33, 1'b0, "kill_new1");
        cyc(1'b0, A00, 1'b0, 64'h0,  1'b0, "kill_new2");

        // Load has priority over a simultaneous fetch
        ifu_mstReq_valid = 1'b1;
        ifu_addr         = A08;
        ld_en            = 1'b1;
        ld_idx           = 10'd1;
        ld_data          = 64'hAA;
        #1;
        check_vec("ldpri/ready", 64'(ifu_mstReq_ready), 64'd0);
        tick();
        ld_en = 1'b0;
        cyc(1'b0, A00, 1'b0, 64'h0,  1'b0, "ldpri_noacc");
        cyc(1'b1, A08, 1'b0, 64'h0,  1'b0, "ldraw0");
        cyc(1'b0, A00, 1'b1, 64'hAA, 1'b0, "ldraw1");
        cyc(1'b0, A00, 1'b0, 64'h0,  1'b0, "ldraw2");

        // Kill and load together: write lands, pipe clears
        cyc(1'b1, A00, 1'b0, 64'h0, 1'b0, "kl_a0");
        ifu_mstReq_valid = 1'b0;
        ifu_req_kill     = 1'b1;
        ld_en            = 1'b1;
        ld_idx           = 10'd2;
        ld_data          = 64'hBB;
        tick();
        ifu_req_kill = 1'b0;
        ld_en        = 1'b0;
        check_vec("kl/drop", 64'(ifu_slvRsp_valid), 64'd0);
        cyc(1'b1, A10, 1'b0, 64'h0,  1'b0, "kl_rd0");
        cyc(1'b0, A00, 1'b1, 64'hBB, 1'b0, "kl_rd1");

        // Reset with two requests in flight
        cyc(1'b1, A00, 1'b0, 64'h0,  1'b0, "mrst_a0");
        cyc(1'b1, A08, 1'b1, 64'h11, 1'b0, "mrst_a1");
        ifu_mstReq_valid = 1'b0;
        RST              = 1'b1;
        #1;
        check_vec("mrst/ready", 64'(ifu_mstReq_ready), 64'd0);
        tick();
        check_vec("mrst/valid", 64'(ifu_slvRsp_valid), 64'd0);
        check_vec("mrst/err", 64'(ifu_slvRsp_err), 64'd0);
        check_vec("mrst/data", ifu_data_r, 64'd0);
        RST = 1'b0;
        cyc(1'b0, A00, 1'b0, 64'h0,  1'b0, "mrst_nostale");
        cyc(1'b1, A18, 1'b0, 64'h0,  1'b0, "mrst_rd0");
        cyc(1'b1, A08, 1'b1, 64'h44, 1'b0, "mrst_rd1");
        cyc(1'b0, A00, 1'b1, 64'hAA, 1'b0, "mrst_rd2");
        cyc(1'b0, A00, 1'b0, 64'h0,  1'b0, "mrst_rd3");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule : tb_itcm_responder
